uart_tx_buffered: RTL and testbench

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_tx_buffered_if.sv | 27 ++
 rtl/uart_tx_buffered.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if -- write/status bundle of the buffered UART transmitter.
//   tx_en     : one-cycle write strobe (master -> slave)
//   tx_data   : byte to send, valid with tx_en (master -> slave)
//   tx        : serial line, idle high (slave -> master)
//   busy      : frame on the line or FIFO non-empty (slave -> master)
//   full      : FIFO holds FIFO_DEPTH entries (slave -> master)
//   overflow  : one-cycle pulse when a write was dropped (slave -> master)
interface uart_tx_buffered_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_en;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx;
  logic                 busy;
  logic                 full;
  logic                 overflow;

  modport master (
    output tx_en, tx_data,
    input  tx, busy, full, overflow
  );

  modport slave (
    input  tx_en, tx_data,
    output tx, busy, full, overflow
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered -- UART transmitter (8N1 style, DATA_BITS payload) with a
// small input FIFO. Writes are queued and sent in order, LSB first.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : uart_tx_buffered_if.slave (tx_en, tx_data in; tx, busy, full,
//            overflow out)
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | line high; pops FIFO head into shifter when non-empty
// S_START | start bit (low) for CLKS_PER_BIT cycles
// S_DATA  | DATA_BITS payload bits, LSB first, CLKS_PER_BIT each
// S_STOP  | stop bit (high) for CLKS_PER_BIT cycles
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_buffered_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_full;
  logic                 r_busy;
  logic                 r_overflow;
  logic                 r_tx;
  logic [DATA_BITS-1:0] r_shift;
  logic [CW-1:0]        r_bit_cnt;
  logic [IW-1:0]        r_bit_idx;

  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_bit_end;
  logic                 w_idle_next;
  logic [AW:0]          w_count_next;
  logic [DATA_BITS-1:0] w_shift_nx;

  // A pop frees a slot in the same cycle, so a write while full is still
  // accepted when the FSM is taking the head.
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  assign w_push    = bus.tx_en && (!r_full || w_pop);
  assign w_drop    = bus.tx_en && r_full && !w_pop;
  assign w_bit_end = (r_bit_cnt == BIT_LAST);
  assign w_shift_nx = r_shift >> 1;

  // IDLE with a non-empty FIFO always leaves, so the FSM is idle next cycle
  // only when it stays idle with nothing to pop or finishes a stop bit.
  assign w_idle_next = ((r_state == S_IDLE) && !w_pop) ||
                       ((r_state == S_STOP) && w_bit_end);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + (AW+1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - (AW+1)'(1);
    end
  end

  // Storage is not reset; occupancy is governed by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count    <= w_count_next;
      // Status flags are computed from next-state values so they change on
      // the same edge as the count and FSM, with no lag.
      r_full     <= (w_count_next == CNT_FULL);
      r_busy     <= !(w_idle_next && (w_count_next == '0));
      r_overflow <= w_drop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx      <= 1'b1;
          r_bit_cnt <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (r_bit_idx == IDX_LAST) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + IW'(1);
              r_shift   <= w_shift_nx;
              r_tx      <= w_shift_nx[0];
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end

        default: begin
          r_tx      <= 1'b1;
          r_bit_cnt <= '0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx       = r_tx;
  assign bus.busy     = r_busy;
  assign bus.full     = r_full;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered -- directed bench for uart_tx_buffered with
// CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4. Accepted bytes go into a
// scoreboard queue; a line monitor decodes each 40-cycle frame and compares.
module tb_uart_tx_buffered;

  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  uart_tx_buffered_if #(.DATA_BITS(8)) bus ();

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0] sb_q[$];
  int         gaps[$];
  int         frames;
  int         mon_start_cyc;
  int         ovf_cnt;
  int         low_run;
  int         max_low;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line monitor: samples tx on every falling edge, frames start on a low
  // sample while idle and span exactly FRAME samples.
  initial begin
    bit          active;
    bit          have_end;
    int          k;
    int          end_cyc;
    logic [39:0] bits;
    logic [39:0] exp_bits;
    logic [7:0]  d;
    active   = 0;
    have_end = 0;
    k        = 0;
    end_cyc  = 0;
    frames   = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        active   = 0;
        have_end = 0;
      end else if (!active) begin
        if (bus.tx === 1'b0) begin
          active        = 1;
          bits          = '0;
          k             = 1;
          mon_start_cyc = cyc;
          if (have_end) gaps.push_back(cyc - end_cyc - 1);
        end
      end else begin
        bits[k] = bus.tx;
        k = k + 1;
        if (k == FRAME) begin
          active   = 0;
          have_end = 1;
          end_cyc  = cyc;
          frames   = frames + 1;
          if (sb_q.size() == 0) begin
            chk("unexpected_frame", {24'd0, bits}, 64'd0);
          end else begin
            d = sb_q.pop_front();
            for (int i = 0; i < FRAME; i++) begin
              if (i < CPB) exp_bits[i] = 1'b0;
              else if (i >= 9 * CPB) exp_bits[i] = 1'b1;
              else exp_bits[i] = d[(i / CPB) - 1];
            end
            chk("frame", {24'd0, bits}, {24'd0, exp_bits});
          end
        end
      end
    end
  end

  initial begin
    ovf_cnt = 0;
    low_run = 0;
    max_low = 0;
    forever begin
      @(negedge clk);
      if (bus.overflow === 1'b1) ovf_cnt = ovf_cnt + 1;
      if (bus.tx === 1'b0) begin
        low_run = low_run + 1;
      end else begin
        if (low_run > max_low) max_low = low_run;
        low_run = 0;
      end
    end
  end

  task automatic push_byte(input logic [7:0] d, input bit accept);
    bus.tx_en   = 1'b1;
    bus.tx_data = d;
    if (accept) sb_q.push_back(d);
    @(negedge clk);
    bus.tx_en = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < maxc) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("idle_timeout", {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    int c0;
    int f0;
    int ovf0;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.tx_en   = 1'b0;
    bus.tx_data = '0;
    repeat (3) @(negedge clk);

    chk("rst_tx",       {63'd0, bus.tx},       64'd1);
    chk("rst_busy",     {63'd0, bus.busy},     64'd0);
    chk("rst_full",     {63'd0, bus.full},     64'd0);
    chk("rst_overflow", {63'd0, bus.overflow}, 64'd0);

    // Single byte, pushed on the first edge after reset release.
    rst_n = 1'b1;
    c0 = cyc;
    push_byte(8'hA5, 1);
    chk("lat_pre_tx", {63'd0, bus.tx},   64'd1);
    chk("busy_push",  {63'd0, bus.busy}, 64'd1);
    @(negedge clk);
    chk("lat_start",  {63'd0, bus.tx},   64'd0);
    wait_cyc(c0 + 1 + FRAME);
    chk("busy_last_stop", {63'd0, bus.busy}, 64'd1);
    @(negedge clk);
    chk("busy_fall",  {63'd0, bus.busy}, 64'd0);
    chk("start_cyc",  64'(mon_start_cyc), 64'(c0 + 2));
    chk("a5_drained", 64'(sb_q.size()),   64'd0);

    // Five consecutive strobes from idle.
    repeat (3) @(negedge clk);
    gaps.delete();
    ovf0 = ovf_cnt;
    f0   = frames;
    for (int i = 1; i <= 5; i++) push_byte(8'(i), 1);
    wait_idle(600);
    chk("five_frames", 64'(frames - f0),   64'd5);
    chk("five_no_ovf", 64'(ovf_cnt - ovf0), 64'd0);
    chk("five_gaps_n", 64'(gaps.size()),   64'd5);
    for (int i = 1; i < 5; i++) chk("five_gap", 64'(gaps[i]), 64'd1);
    chk("five_drained", 64'(sb_q.size()),  64'd0);

    // Fill while a frame is active, drop 0xFF, then push on the pop cycle.
    repeat (3) @(negedge clk);
    ovf0 = ovf_cnt;
    f0   = frames;
    c0   = cyc;
    push_byte(8'h11, 1);
    wait_cyc(c0 + 3);
    push_byte(8'h22, 1);
    push_byte(8'h33, 1);
    push_byte(8'h44, 1);
    push_byte(8'h55, 1);
    chk("fill_full",     {63'd0, bus.full},     64'd1);
    chk("fill_no_ovf",   {63'd0, bus.overflow}, 64'd0);
    push_byte(8'hFF, 0);
    chk("drop_ovf",      {63'd0, bus.overflow}, 64'd1);
    chk("drop_full",     {63'd0, bus.full},     64'd1);
    @(negedge clk);
    chk("drop_ovf_end",  {63'd0, bus.overflow}, 64'd0);
    wait_cyc(c0 + 2 + FRAME);
    chk("pop_cyc_full",  {63'd0, bus.full},     64'd1);
    push_byte(8'h66, 1);
    chk("pushpop_ovf",   {63'd0, bus.overflow}, 64'd0);
    chk("pushpop_full",  {63'd0, bus.full},     64'd1);
    wait_idle(2000);
    chk("fill_ovf_cnt",  64'(ovf_cnt - ovf0),   64'd1);
    chk("fill_frames",   64'(frames - f0),      64'd6);
    chk("fill_drained",  64'(sb_q.size()),      64'd0);

    // Reset in the middle of data bit 3 with two entries queued.
    repeat (3) @(negedge clk);
    c0 = cyc;
    push_byte(8'h00, 0);
    wait_cyc(c0 + 3);
    push_byte(8'hAA, 0);
    push_byte(8'hBB, 0);
    wait_cyc(c0 + 2 + CPB + 3 * CPB + 1);
    chk("mid_bit3_low", {63'd0, bus.tx},   64'd0);
    chk("mid_full",     {63'd0, bus.full}, 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_tx",       {63'd0, bus.tx},       64'd1);
    chk("arst_busy",     {63'd0, bus.busy},     64'd0);
    chk("arst_full",     {63'd0, bus.full},     64'd0);
    chk("arst_overflow", {63'd0, bus.overflow}, 64'd0);
    f0 = frames;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("post_rst_frames", 64'(frames - f0), 64'd0);
    chk("post_rst_tx",     {63'd0, bus.tx},   64'd1);
    chk("post_rst_busy",   {63'd0, bus.busy}, 64'd0);

    // 0x00 then 0xFF back-to-back.
    gaps.delete();
    f0      = frames;
    max_low = 0;
    push_byte(8'h00, 1);
    push_byte(8'hFF, 1);
    wait_idle(300);
    @(negedge clk);
    chk("zf_frames",  64'(frames - f0), 64'd2);
    chk("zf_max_low", 64'(max_low),     64'd36);
    chk("zf_gaps_n",  64'(gaps.size()), 64'd1);
    if (gaps.size() > 0) chk("zf_gap", 64'(gaps[0]), 64'd1);
    chk("zf_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
